// File: rtl/tempo_picker_pkg.sv
// tempo_pkg: shared types and elaboration-time helpers for tempo_picker.
//   state_t           - estimator FSM states
//   clog2()           - ceiling log2, never below 1 (used for index/counter widths)
//   beat_period()     - beat period in clk cycles for a BPM value (0 for bpm 0)
//   DEFAULT_TEMPO_BPM - packed BPM list, channel 5 in the top byte
package tempo_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQUARE,
    S_ACCUM,
    S_SCAN,
    S_UPDATE
  } state_t;

  localparam logic [47:0] DEFAULT_TEMPO_BPM = {8'd240, 8'd210, 8'd180, 8'd120, 8'd90, 8'd60};

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned beat_period(input int unsigned k, input int unsigned bpm);
    return (bpm == 0) ? 0 : k / bpm;
  endfunction

endpackage

// File: rtl/tempo_picker_beat_gen.sv
// beat_gen: free-running beat pulse generator.
//   clk, reset_n : clock, asynchronous active-low reset
//   period       : new beat period in clk cycles (0 = no beat)
//   load         : one-cycle strobe, latches period for the next reload
//   beat         : one-cycle pulse every period cycles
// A newly loaded period only takes effect when the down-counter next reloads,
// so the beat in flight is never truncated or duplicated.
module beat_gen #(
  parameter int unsigned PW = 19
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [PW-1:0] period,
  input  logic          load,
  output logic          beat
);

  logic [PW-1:0] period_q;
  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      cnt      <= '0;
      beat     <= 1'b0;
    end else begin
      if (load) period_q <= period;
      if (cnt == '0) begin
        if (period_q == '0) begin
          beat <= 1'b0;
        end else begin
          beat <= 1'b1;
          cnt  <= period_q - PW'(1);
        end
      end else begin
        beat <= 1'b0;
        cnt  <= cnt - PW'(1);
      end
    end
  end

endmodule

// File: rtl/tempo_picker.sv
// tempo_picker: comb-filter tempo estimator with beat output.
//   clk, reset_n : clock, asynchronous active-low reset
//   ready        : one-cycle strobe, comb_in valid
//   comb_in      : NTEMPO*NBANDS signed samples, element [t*NBANDS+b]
//   tempo        : selected BPM (0 = none yet)
//   tempo_idx    : selected channel
//   max_energy   : energy of the selected channel in the last scan
//   beat         : one-cycle pulse at the selected tempo
//   est_done     : one-cycle pulse at the end of each scan
//   overrun      : sticky, ready arrived while busy
// Build option TEMPO_DECAY_EN: leaky accumulation instead of window clear.
module tempo_picker
  import tempo_pkg::*;
#(
  parameter int unsigned             DW        = 8,
  parameter int unsigned             NBANDS    = 5,
  parameter int unsigned             NTEMPO    = 6,
  parameter int unsigned             ACCW      = 24,
  parameter int unsigned             WINDOW    = 4096,
  parameter logic [NTEMPO*8-1:0]     TEMPO_BPM = DEFAULT_TEMPO_BPM,
  parameter int unsigned             PERIOD_K  = 360000,
  parameter int unsigned             DECAY_SH  = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ready,
  input  logic [NTEMPO*NBANDS*DW-1:0]   comb_in,
  output logic [7:0]                    tempo,
  output logic [clog2(NTEMPO)-1:0]      tempo_idx,
  output logic [ACCW-1:0]               max_energy,
  output logic                          beat,
  output logic                          est_done,
  output logic                          overrun
);

  localparam int unsigned IW = clog2(NTEMPO);
  localparam int unsigned EW = 2 * DW + clog2(NBANDS);
  localparam int unsigned PW = clog2(PERIOD_K + 1);
  localparam int unsigned CW = clog2(WINDOW);
  localparam int unsigned SW = ((ACCW > EW) ? ACCW : EW) + 1;
  localparam logic [ACCW-1:0] ACC_MAX = '1;

  state_t                 state;
  logic signed [DW-1:0]   samp    [NTEMPO*NBANDS];
  logic        [EW-1:0]   e       [NTEMPO];
  logic        [EW-1:0]   e_next  [NTEMPO];
  logic        [ACCW-1:0] acc     [NTEMPO];
  logic        [SW-1:0]   acc_sum [NTEMPO];
  logic signed [2*DW-1:0] sq;
  logic        [ACCW-1:0] best;
  logic        [IW-1:0]   best_idx;
  logic        [IW-1:0]   scan_idx;
  logic        [CW-1:0]   win_cnt;
`ifndef TEMPO_DECAY_EN
  logic                   win_end;
`endif
  logic        [PW-1:0]   period_val;
  logic                   period_load;
  logic        [7:0]      bpm_tab    [NTEMPO];
  logic        [PW-1:0]   period_tab [NTEMPO];

  for (genvar g = 0; g < NTEMPO; g++) begin : g_tab
    assign bpm_tab[g]    = TEMPO_BPM[g*8 +: 8];
    assign period_tab[g] = PW'(beat_period(PERIOD_K, TEMPO_BPM[g*8 +: 8]));
  end

  always_comb begin
    sq = '0;
    for (int unsigned t = 0; t < NTEMPO; t++) begin
      e_next[t] = '0;
      for (int unsigned b = 0; b < NBANDS; b++) begin
        sq        = samp[t*NBANDS+b] * samp[t*NBANDS+b];
        e_next[t] = e_next[t] + EW'($unsigned(sq));
      end
    end
  end

  // Sum is one bit wider than both operands so saturation sees the carry.
  always_comb begin
    for (int unsigned t = 0; t < NTEMPO; t++) begin
`ifdef TEMPO_DECAY_EN
      acc_sum[t] = SW'(acc[t]) - SW'(acc[t] >> DECAY_SH) + SW'(e[t]);
`else
      acc_sum[t] = SW'(acc[t]) + SW'(e[t]);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      for (int unsigned i = 0; i < NTEMPO*NBANDS; i++) samp[i] <= '0;
      for (int unsigned t = 0; t < NTEMPO; t++) begin
        e[t]   <= '0;
        acc[t] <= '0;
      end
      best        <= '0;
      best_idx    <= '0;
      scan_idx    <= '0;
      win_cnt     <= '0;
`ifndef TEMPO_DECAY_EN
      win_end     <= 1'b0;
`endif
      tempo       <= '0;
      tempo_idx   <= '0;
      max_energy  <= '0;
      est_done    <= 1'b0;
      overrun     <= 1'b0;
      period_val  <= '0;
      period_load <= 1'b0;
    end else begin
      est_done    <= 1'b0;
      period_load <= 1'b0;
      if (ready && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ready) begin
            for (int unsigned i = 0; i < NTEMPO*NBANDS; i++) samp[i] <= comb_in[i*DW +: DW];
            state <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          for (int unsigned t = 0; t < NTEMPO; t++) e[t] <= e_next[t];
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          for (int unsigned t = 0; t < NTEMPO; t++)
            acc[t] <= (acc_sum[t] > SW'(ACC_MAX)) ? ACC_MAX : acc_sum[t][ACCW-1:0];
          if (win_cnt == CW'(WINDOW - 1)) begin
            win_cnt <= '0;
`ifndef TEMPO_DECAY_EN
            win_end <= 1'b1;
`endif
          end else begin
            win_cnt <= win_cnt + CW'(1);
`ifndef TEMPO_DECAY_EN
            win_end <= 1'b0;
`endif
          end
          best     <= '0;
          best_idx <= '0;
          scan_idx <= IW'(NTEMPO - 1);
          state    <= S_SCAN;
        end
        S_SCAN: begin
          // Scanning downward with strict '>' keeps the higher channel on a tie.
          if (acc[scan_idx] > best) begin
            best     <= acc[scan_idx];
            best_idx <= scan_idx;
          end
          if (scan_idx == '0) state <= S_UPDATE;
          else                scan_idx <= scan_idx - IW'(1);
        end
        S_UPDATE: begin
          if (best != '0) begin
            tempo       <= bpm_tab[best_idx];
            tempo_idx   <= best_idx;
            max_energy  <= best;
            period_val  <= period_tab[best_idx];
            period_load <= 1'b1;
          end
          est_done <= 1'b1;
`ifndef TEMPO_DECAY_EN
          if (win_end)
            for (int unsigned t = 0; t < NTEMPO; t++) acc[t] <= '0;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  beat_gen #(
    .PW(PW)
  ) u_beat_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .period (period_val),
    .load   (period_load),
    .beat   (beat)
  );

endmodule

// File: tb/tb_tempo_picker.sv
module tb_tempo_picker;

  localparam int DW = 8, NBANDS = 5, NTEMPO = 6, ACCW = 16, WINDOW = 4;
  localparam int VW = NTEMPO * NBANDS * DW;
  localparam int LAT = NTEMPO + 3;
  typedef logic [VW-1:0] vec_t;

  typedef struct {
    logic [7:0]      tempo;
    logic [2:0]      idx;
    logic [ACCW-1:0] energy;
    int              due;
    bit              chk;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic            ready;
  vec_t            comb_in;
  logic [7:0]      tempo;
  logic [2:0]      tempo_idx;
  logic [ACCW-1:0] max_energy;
  logic            beat;
  logic            est_done;
  logic            overrun;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   est_cnt = 0;
  exp_t exp_q[$];

  tempo_picker #(
    .DW(DW), .NBANDS(NBANDS), .NTEMPO(NTEMPO), .ACCW(ACCW), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .comb_in(comb_in),
    .tempo(tempo), .tempo_idx(tempo_idx), .max_energy(max_energy),
    .beat(beat), .est_done(est_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard monitor: every est_done must match the oldest expected entry.
  always @(negedge clk) begin
    if (est_done) begin
      exp_t x;
      est_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_est_done", 1, 0);
      end else begin
        x = exp_q.pop_front();
        check("latency", cyc, x.due);
        if (x.chk) begin
          check("tempo", tempo, x.tempo);
          check("tempo_idx", tempo_idx, x.idx);
          check("max_energy", max_energy, x.energy);
        end
      end
    end
  end

  function automatic vec_t put(input vec_t v, input int ch, input int band, input logic [7:0] val);
    vec_t r = v;
    r[(ch*NBANDS+band)*DW +: DW] = val;
    return r;
  endfunction

  function automatic vec_t fill(input vec_t v, input int ch, input logic [7:0] val);
    vec_t r = v;
    for (int b = 0; b < NBANDS; b++) r = put(r, ch, b, val);
    return r;
  endfunction

  task automatic send(input vec_t v, input bit push, input logic [7:0] t, input logic [2:0] i,
                      input logic [ACCW-1:0] en, input bit chk);
    @(negedge clk);
    comb_in = v;
    ready   = 1'b1;
    if (push) exp_q.push_back('{t, i, en, cyc + 1 + LAT, chk});
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic next_beat(output int t);
    int n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!beat && n < 8000);
    if (beat) t = cyc;
    else check("beat_timeout", 0, 1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, 0 vs 1");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   t0, t1, t2, t3, t4, n0;

    reset_n = 1'b0;
    ready   = 1'b0;
    comb_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_tempo", tempo, 0);
    check("rst_tempo_idx", tempo_idx, 0);
    check("rst_max_energy", max_energy, 0);
    check("rst_beat", beat, 0);
    check("rst_est_done", est_done, 0);
    check("rst_overrun", overrun, 0);

    // Single dominant tempo: channel 2 (120 BPM), bands at 100 -> 5*10000.
    v = fill('0, 2, 8'd100);
    send(v, 1, 8'd120, 3'd2, 16'd50000, 1);
    settle();

    // Reset in the middle of a scan discards it.
    n0 = est_cnt;
    send(v, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midscan_tempo", tempo, 0);
    check("midscan_tempo_idx", tempo_idx, 0);
    check("midscan_max_energy", max_energy, 0);
    check("midscan_est_done", est_done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midscan_no_est_done", est_cnt, n0);

    // Tie between 240 (ch5) and 120 (ch2): higher channel wins.
    do_reset();
    v = fill(fill('0, 5, 8'd100), 2, 8'd100);
    send(v, 1, 8'd240, 3'd5, 16'd50000, 1);
    settle();

    do_reset();
`ifdef TEMPO_DECAY_EN
    // e = 20^2 + 20^2 = 800 each sample; acc - acc>>3 + 800 settles at 6400.
    v = put(put('0, 2, 0, 8'd20), 2, 1, 8'd20);
    send(v, 1, 8'd120, 3'd2, 16'd800, 1);  settle();
    send(v, 1, 8'd120, 3'd2, 16'd1500, 1); settle();
    send(v, 1, 8'd120, 3'd2, 16'd2113, 1); settle();
    for (int k = 0; k < 100; k++) begin
      send(v, 1, 8'd120, 3'd2, 16'd0, 0);
      settle();
    end
    send(v, 1, 8'd120, 3'd2, 16'd6400, 1); settle();
`else
    // Window of 4: e = 5*100 = 500, accumulators clear after the 4th update.
    v = fill('0, 2, 8'd10);
    send(v, 1, 8'd120, 3'd2, 16'd500, 1);  settle();
    send(v, 1, 8'd120, 3'd2, 16'd1000, 1); settle();
    send(v, 1, 8'd120, 3'd2, 16'd1500, 1); settle();
    send(v, 1, 8'd120, 3'd2, 16'd2000, 1); settle();
    send(v, 1, 8'd120, 3'd2, 16'd500, 1);  settle();
`endif

    // Saturation: all samples -128 -> e = 81920 per channel, clipped to 65535.
    do_reset();
    v = '0;
    for (int c = 0; c < NTEMPO; c++) v = fill(v, c, 8'h80);
    send(v, 1, 8'd240, 3'd5, 16'd65535, 1); settle();
    send(v, 1, 8'd240, 3'd5, 16'd65535, 1); settle();
    check("overrun_before", overrun, 0);

    // Two ready strobes 2 cycles apart: second is dropped.
    @(negedge clk);
    comb_in = v;
    ready   = 1'b1;
    exp_q.push_back('{8'd240, 3'd5, 16'd65535, cyc + 1 + LAT, 1'b1});
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    settle();
    check("overrun_after", overrun, 1);

    // Beat: 240 BPM -> 1500 cycles; switch to 60 BPM -> 1500 then 6000.
    do_reset();
    send(fill('0, 5, 8'd100), 1, 8'd240, 3'd5, 16'd50000, 1);
    settle();
    next_beat(t0);
    next_beat(t1);
    next_beat(t2);
    check("beat_gap_240_a", t1 - t0, 1500);
    check("beat_gap_240_b", t2 - t1, 1500);
    send(fill('0, 0, 8'd127), 1, 8'd60, 3'd0, 16'd65535, 1);
    next_beat(t3);
    next_beat(t4);
    check("beat_gap_switch", t3 - t2, 1500);
    check("beat_gap_60", t4 - t3, 6000);

    repeat (5) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
